// File: rtl/noc_pkg.sv
// Shared flit layout for the PCI <-> torus NoC bridge.
// A flit is {payload, y_dst, x_dst} with x_dst in the least significant bits.
package noc_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned XW     = 2;
    localparam int unsigned YW     = 2;
    localparam int unsigned X_LSB  = 0;
    localparam int unsigned Y_LSB  = XW;
    localparam int unsigned D_LSB  = XW + YW;
    localparam int unsigned FLIT_W = DATA_W + XW + YW;

    // Field order matches the flit header: y above x.
    typedef struct packed {
        logic [YW-1:0] y;
        logic [XW-1:0] x;
    } node_xy_t;

    // Linear node index to torus coordinates: x = idx / rows, y = idx % rows.
    function automatic node_xy_t node_xy(input int unsigned idx, input int unsigned rows);
        node_xy_t c;
        c.x = XW'(idx / rows);
        c.y = YW'(idx % rows);
        return c;
    endfunction

endpackage

// File: rtl/noc_rx_fifo.sv
// First-word-fall-through synchronous FIFO used as the egress return buffer.
// Pointers carry one extra MSB so full and empty are distinguishable.
module noc_rx_fifo #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_q, wr_d;
    logic [AW:0]      rd_q, rd_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign data_o  = mem_q[rd_q[AW-1:0]];

    // Pointer next-state: each pointer advances only on its own accepted operation.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        wr_d = wr_q;
        rd_d = rd_q;
        if (do_push) wr_d = wr_q + 1'b1;
        if (do_pop)  rd_d = rd_q + 1'b1;
    end

    // Pointer registers, cleared asynchronously to the empty state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    // Storage write port.
    // NOTE: the array is deliberately not reset; empty pointers make its contents unobservable.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/pci_noc_bridge.sv
// Bridge between the host PCI stream and the NoC injection port of node (0,0).
// Ingress packs PCI words into flits addressed round-robin to nodes 1..X*Y-1;
// egress strips headers from returning flits and streams payloads back to PCI.
// Credits bound in-flight packets to DEPTH so the return buffer cannot overflow.
// Optional macro PCI_NOC_BRIDGE_STATS_EN adds o_tx_cnt / o_rx_cnt handshake counters.
module pci_noc_bridge
    import noc_pkg::*;
#(
    parameter int unsigned X     = 4,
    parameter int unsigned Y     = 4,
    parameter int unsigned DEPTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid_pci,
    input  logic [DATA_W-1:0] i_data_pci,
    output logic              o_ready_pci,
    output logic [DATA_W-1:0] o_data_pci,
    output logic              o_valid_pci,
    input  logic              i_ready_pci,
    output logic              o_valid_noc,
    output logic [FLIT_W-1:0] o_data_noc,
    input  logic              i_ready_noc,
    input  logic              i_valid_noc,
    input  logic [FLIT_W-1:0] i_data_noc,
    output logic              o_ready_noc
`ifdef PCI_NOC_BRIDGE_STATS_EN
    ,
    output logic [31:0]       o_tx_cnt,
    output logic [31:0]       o_rx_cnt
`endif
);

    localparam int unsigned NODES = X * Y;
    localparam int unsigned DW    = $clog2(NODES);
    localparam int unsigned CW    = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CRED_MAX = CW'(DEPTH);

    logic [CW-1:0]     credit_q, credit_d;
    logic [DW-1:0]     dest_q, dest_d;
    logic              valid_noc_q, valid_noc_d;
    logic [FLIT_W-1:0] flit_q, flit_d;
    node_xy_t          dst;
    logic              pci_accept, noc_fire, pci_fire;
    logic              fifo_push, fifo_full, fifo_empty;
    logic              unused_hdr;

    assign dst         = node_xy(32'(dest_q), Y);
    assign o_ready_pci = (credit_q != '0) && (!valid_noc_q || i_ready_noc);
    assign pci_accept  = i_valid_pci && o_ready_pci;
    assign noc_fire    = valid_noc_q && i_ready_noc;
    assign pci_fire    = o_valid_pci && i_ready_pci;
    assign o_valid_noc = valid_noc_q;
    assign o_data_noc  = flit_q;
    assign o_ready_noc = !fifo_full;
    assign o_valid_pci = !fifo_empty;
    assign fifo_push   = i_valid_noc && o_ready_noc;
    assign unused_hdr  = ^i_data_noc[D_LSB-1:0];

    // Ingress: load a new flit on accept, otherwise drop valid once the NoC takes it.
    always_comb begin
        valid_noc_d = valid_noc_q;
        flit_d      = flit_q;
        dest_d      = dest_q;
        if (pci_accept) begin
            flit_d      = {i_data_pci, dst};
            valid_noc_d = 1'b1;
            dest_d      = (dest_q == DW'(NODES - 1)) ? DW'(1) : dest_q + DW'(1);
        end else if (noc_fire) begin
            valid_noc_d = 1'b0;
        end
    end

    // Credits: spend on accept, refund on PCI egress, hold when both happen, cap at DEPTH.
    always_comb begin
        credit_d = credit_q;
        if (pci_accept && !pci_fire) begin
            credit_d = credit_q - CW'(1);
        end else if (pci_fire && !pci_accept && credit_q != CRED_MAX) begin
            credit_d = credit_q + CW'(1);
        end
    end

    // Ingress and credit state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            credit_q    <= CRED_MAX;
            dest_q      <= DW'(1);
            valid_noc_q <= 1'b0;
            flit_q      <= '0;
        end else begin
            credit_q    <= credit_d;
            dest_q      <= dest_d;
            valid_noc_q <= valid_noc_d;
            flit_q      <= flit_d;
        end
    end

    noc_rx_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (DEPTH)
    ) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .data_i  (i_data_noc[FLIT_W-1 -: DATA_W]),
        .pop_i   (i_ready_pci),
        .data_o  (o_data_pci),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

`ifdef PCI_NOC_BRIDGE_STATS_EN
    logic [31:0] tx_cnt_q, rx_cnt_q;

    // Free-running handshake counters, wrapping modulo 2**32.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
        end else begin
            if (noc_fire)  tx_cnt_q <= tx_cnt_q + 32'd1;
            if (fifo_push) rx_cnt_q <= rx_cnt_q + 32'd1;
        end
    end

    assign o_tx_cnt = tx_cnt_q;
    assign o_rx_cnt = rx_cnt_q;
`endif

endmodule

// File: tb/tb_pci_noc_bridge.sv
// Self-checking bench for pci_noc_bridge (X=Y=4, DEPTH=8, 32-bit payload).
// A transaction-level model (integer credits, integer destination index,
// payload queue) predicts every output; directed steps follow the test plan,
// then a randomized phase exercises all handshakes together.
module tb_pci_noc_bridge;

    localparam int DEPTH = 8;
    localparam int NX    = 4;
    localparam int NY    = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_valid_pci, i_ready_pci, i_ready_noc, i_valid_noc;
    logic [31:0] i_data_pci;
    logic [35:0] i_data_noc;
    logic        o_ready_pci, o_valid_pci, o_valid_noc, o_ready_noc;
    logic [31:0] o_data_pci;
    logic [35:0] o_data_noc;

    int tests = 0;
    int fails = 0;
    int obs_acc = 0;

    // Reference model state
    int          m_cred;
    int          m_dest;
    bit          m_vnoc;
    logic [35:0] m_flit;
    logic [31:0] m_fifo[$];

    pci_noc_bridge #(.X(NX), .Y(NY), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_valid_pci (i_valid_pci),
        .i_data_pci  (i_data_pci),
        .o_ready_pci (o_ready_pci),
        .o_data_pci  (o_data_pci),
        .o_valid_pci (o_valid_pci),
        .i_ready_pci (i_ready_pci),
        .o_valid_noc (o_valid_noc),
        .o_data_noc  (o_data_noc),
        .i_ready_noc (i_ready_noc),
        .i_valid_noc (i_valid_noc),
        .i_data_noc  (i_data_noc),
        .o_ready_noc (o_ready_noc)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: observed no finish, expected finish within bound");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cred = DEPTH;
        m_dest = 1;
        m_vnoc = 1'b0;
        m_flit = '0;
        m_fifo.delete();
    endtask

    // One clock: drive inputs, compare all outputs to the model, clock, update the model.
    task automatic cycle(input bit v_pci, input logic [31:0] d_pci, input bit r_pci,
                         input bit r_noc, input bit v_noc, input logic [35:0] d_noc);
        bit exp_rdy, acc, nfire, efire, push;
        i_valid_pci = v_pci;
        i_data_pci  = d_pci;
        i_ready_pci = r_pci;
        i_ready_noc = r_noc;
        i_valid_noc = v_noc;
        i_data_noc  = d_noc;
        #1;
        exp_rdy = (m_cred != 0) && (!m_vnoc || r_noc);
        check("ready_pci", 64'(o_ready_pci), 64'(exp_rdy));
        check("valid_noc", 64'(o_valid_noc), 64'(m_vnoc));
        if (m_vnoc) begin
            check("data_noc", 64'(o_data_noc), 64'(m_flit));
            check("not_node0", 64'(o_data_noc[3:0] != 4'd0), 64'd1);
        end
        check("valid_pci", 64'(o_valid_pci), 64'(m_fifo.size() != 0));
        if (m_fifo.size() != 0) check("data_pci", 64'(o_data_pci), 64'(m_fifo[0]));
        check("ready_noc", 64'(o_ready_noc), 64'(m_fifo.size() < DEPTH));
        if (v_pci && o_ready_pci) obs_acc++;

        acc   = v_pci && exp_rdy;
        nfire = m_vnoc && r_noc;
        efire = (m_fifo.size() != 0) && r_pci;
        push  = v_noc && (m_fifo.size() < DEPTH);

        @(posedge clk);
        #1;
        if (acc && !efire) m_cred = m_cred - 1;
        else if (efire && !acc && m_cred < DEPTH) m_cred = m_cred + 1;
        if (acc) begin
            m_flit = {d_pci, 2'(m_dest % NY), 2'(m_dest / NY)};
            m_vnoc = 1'b1;
            m_dest = (m_dest == NX * NY - 1) ? 1 : m_dest + 1;
        end else if (nfire) begin
            m_vnoc = 1'b0;
        end
        if (efire) void'(m_fifo.pop_front());
        if (push) m_fifo.push_back(d_noc[35:4]);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (m_fifo.size() != 0 || m_vnoc) cycle(0, 32'd0, 1, 1, 0, 36'd0);
        end
    endtask

    initial begin
        i_valid_pci = 0; i_data_pci = 0; i_ready_pci = 0;
        i_ready_noc = 0; i_valid_noc = 0; i_data_noc = 0;

        // 1. Reset values while rst is held low
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_noc", 64'(o_valid_noc), 64'd0);
        check("rst_data_noc",  64'(o_data_noc),  64'd0);
        check("rst_valid_pci", 64'(o_valid_pci), 64'd0);
        check("rst_ready_pci", 64'(o_ready_pci), 64'd1);
        check("rst_ready_noc", 64'(o_ready_noc), 64'd1);
        rst = 1'b1;
        model_reset();

        // First word goes to node 1 = (x=0, y=1) one cycle after accept
        cycle(1, 32'hA5A5A5A5, 0, 1, 0, 36'd0);
        check("first_flit", 64'(o_data_noc), 64'h0_0000_000A_5A5A_5A54 & 64'hF_FFFF_FFFF);
        cycle(0, 32'd0, 0, 1, 0, 36'd0);

        // 2. Round-robin: 16 back-to-back words, results looped back to keep credits flowing
        for (int i = 0; i < 16; i++) cycle(1, $urandom, 1, 1, 1, {32'($urandom), 4'($urandom_range(0, 15))});
        drain();

        // 3. Backpressure: flit pending while the NoC stalls
        cycle(1, $urandom, 0, 0, 0, 36'd0);
        for (int i = 0; i < 5; i++) cycle(1, $urandom, 0, 0, 0, 36'd0);
        check("bp_ready_pci", 64'(o_ready_pci), 64'd0);
        cycle(1, $urandom, 0, 1, 0, 36'd0);
        cycle(0, 32'd0, 0, 1, 0, 36'd0);

        // 4. Credit limit: send until credits run out, then return one
        for (int i = 0; i < 10; i++) cycle(1, $urandom, 0, 1, 0, 36'd0);
        check("cred_block", 64'(o_ready_pci), 64'd0);
        cycle(0, 32'd0, 0, 1, 1, {32'h1234_5678, 4'h9});
        cycle(0, 32'd0, 1, 1, 0, 36'd0);
        check("cred_return", 64'(o_ready_pci), 64'd1);

        // 5. Egress ordering with header stripping and simultaneous push/pop
        cycle(0, 32'd0, 0, 1, 1, {32'd1, 4'hF});
        cycle(0, 32'd0, 1, 1, 1, {32'd2, 4'hA});
        check("simul_head", 64'(o_data_pci), 64'd2);
        cycle(0, 32'd0, 0, 1, 1, {32'd3, 4'h5});
        for (int i = 0; i < 6; i++) cycle(0, 32'd0, 1'(i % 2), 1, 0, 36'd0);

        // Randomized mixed traffic
        for (int i = 0; i < 300; i++)
            cycle(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  {32'($urandom), 4'($urandom_range(0, 15))});
        drain();

        // 6. Full FIFO from unsolicited flits, then reset mid-stream
        for (int i = 0; i < 9; i++) cycle(0, 32'd0, 0, 1, 1, {32'($urandom), 4'($urandom_range(0, 15))});
        check("full_ready_noc", 64'(o_ready_noc), 64'd0);
        check("full_valid_pci", 64'(o_valid_pci), 64'd1);
        cycle(1, $urandom, 0, 0, 1, {32'hDEAD_BEEF, 4'h1});
        rst = 1'b0;
        #1;
        model_reset();
        check("mid_rst_valid_pci", 64'(o_valid_pci), 64'd0);
        check("mid_rst_valid_noc", 64'(o_valid_noc), 64'd0);
        check("mid_rst_ready_noc", 64'(o_ready_noc), 64'd1);
        check("mid_rst_ready_pci", 64'(o_ready_pci), 64'd1);
        @(posedge clk);
        #1;
        rst = 1'b1;
        obs_acc = 0;
        for (int i = 0; i < 10; i++) cycle(1, $urandom, 0, 1, 0, 36'd0);
        check("cred_after_rst", 64'(obs_acc), 64'd8);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pci_noc_bridge.md
Name: pci_noc_bridge

Overview:
Scheduler stage between the host PCI stream and the torus NoC injection port of node (0,0).
- Ingress: packs each PCI word into a NoC flit addressed round-robin to the compute nodes.
- Egress: buffers result flits returning from the NoC, strips their headers and streams the payload back to PCI.
- A credit counter bounds in-flight packets so the return buffer can never overflow.

Parameters:
DATA_W, `data_width, payload width in bits.
X, `X, torus columns.
Y, `Y, torus rows.
XW, 2, x-coordinate field width; must satisfy 2**XW >= X.
YW, 2, y-coordinate field width; must satisfy 2**YW >= Y.
FLIT_W, DATA_W+XW+YW, flit width; equals `total_width.
DEPTH, 8, return FIFO depth (power of two); also the maximum number of in-flight packets.

Ports:
clk  in  1  clock.
rst  in  1  reset; asynchronous assert, active-low (0 = reset).
i_valid_pci  in  1  PCI word valid.
i_data_pci  in  DATA_W  PCI word.
o_ready_pci  out  1  bridge accepts the PCI word.
o_data_pci  out  DATA_W  result payload to PCI.
o_valid_pci  out  1  result valid.
i_ready_pci  in  1  PCI accepts result.
o_valid_noc  out  1  flit valid to node (0,0) injection.
o_data_noc  out  FLIT_W  flit {payload, y_dst, x_dst}; x_dst in LSBs.
i_ready_noc  in  1  node (0,0) accepts flit.
i_valid_noc  in  1  result flit valid from node (0,0).
i_data_noc  in  FLIT_W  result flit.
o_ready_noc  out  1  bridge accepts result flit.

Behaviour:
Reset values:
- o_valid_noc=0, o_data_noc=0, o_valid_pci=0.
- o_ready_pci=1, o_ready_noc=1.
- credits=DEPTH, dest index=1, FIFO empty.
- o_data_pci is don't-care while o_valid_pci=0.

Handshakes:
- Transfer occurs on valid&&ready.
- Valid and data are held stable until accepted.
- Valid never depends combinationally on ready.

Ingress:
- o_ready_pci = (credits!=0) && (!o_valid_noc || i_ready_noc).
- On PCI accept, the output register loads {i_data_pci, y_dst, x_dst} and o_valid_noc=1 on the next cycle. Latency is 1 cycle.
- Back-to-back accepts are allowed when i_ready_noc=1.
- o_valid_noc clears after a NoC handshake if no new accept occurs in the same cycle.

Destination scheduling:
- dest index d cycles 1..X*Y-1, then wraps to 1. Node 0 (the bridge's own node) is never targeted.
- x_dst = d / Y, y_dst = d % Y.
- d advances only on a PCI accept.

Credits:
- Decrement on PCI accept; increment on PCI egress handshake.
- Simultaneous accept and egress: credits unchanged.
- Saturates at DEPTH, so an increment at DEPTH is ignored. A decrement at 0 cannot occur because o_ready_pci=0.

Egress:
- FIFO of DEPTH x DATA_W, first-word-fall-through.
- o_ready_noc = !full.
- Push stores i_data_noc[FLIT_W-1 -: DATA_W]; header bits are discarded.
- o_valid_pci = !empty; o_data_pci = head entry.
- Push into an empty FIFO is visible on o_valid_pci the next cycle (1-cycle latency).
- Simultaneous push and pop when not full: both occur and the count is unchanged.
- When full, o_ready_noc=0 and no push occurs; this is reachable only with unsolicited flits.
- Pointers are log2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.

Reset mid-operation:
- All state clears immediately.
- Any flit held in the output register and any FIFO contents are lost; the credits return to DEPTH.

Optional Feature:
PCI_NOC_BRIDGE_STATS_EN
- Defined: adds outputs o_tx_cnt[31:0] (NoC ingress handshakes) and o_rx_cnt[31:0] (NoC egress pushes). Both reset to 0 and wrap modulo 2**32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Decomposition:
Shared package (noc_pkg):
- Flit field widths XW, YW, DATA_W.
- Field offsets: X_LSB=0, Y_LSB=XW, D_LSB=XW+YW.
- Function computing {x,y} from a linear node index.

Sub-module noc_rx_fifo:
- Parameterised by width and depth; FWFT sync FIFO with full/empty.
- Used for the egress buffer.

Test Plan:
1. Reset: with X=Y=4, hold rst=0 → o_valid_noc=0, o_valid_pci=0, o_ready_pci=1. Release rst; send 0xA5A5A5A5 → one cycle later o_data_noc={0xA5A5A5A5, y=1, x=0}.
2. Round-robin: 16 words with i_ready_noc=1 → destinations d=1..15 then 1. Node (0,0) is never targeted; one flit per cycle.
3. Backpressure: i_ready_noc=0 for 5 cycles with a flit pending → o_data_noc held stable and o_ready_pci=0. Release → the next flit follows on the following cycle.
4. Credit limit: 8 words sent, none returned → o_ready_pci=0 after the 8th accept. One PCI egress handshake → o_ready_pci=1 the next cycle.
5. Egress: NoC returns flits with payloads 1,2,3 while i_ready_pci toggles → PCI receives 1,2,3 in order with headers stripped. Simultaneous push and pop leave the count unchanged.
6. Full FIFO: 8 unsolicited flits with i_ready_pci=0 → o_ready_noc=0 and a 9th flit is not accepted. Asserting rst mid-stream → FIFO empty and credits=8.
